nubus_mem_dma: RTL
==================

// Module: nubus_mem_dma
// PURPOSE
//  Bus initiator for the mem_* valid/ready interface served by the on-card memory responder.
//  Copies cmd_len 32-bit words from cmd_src to cmd_dst, one read then one write per word.
//  Used by card firmware/test logic to move blocks between NuBus-mapped memory regions.
//  Drives full-word (wstrb=F) writes only; rdata lanes are sampled only on the ready edge.
// PARAMETERS
//  TIMEOUT_CLOCKS  255  max cycles mem_valid may stay high without mem_ready; 0 = no timeout
//  LEN_W           16   width of word-count fields
// PORTS
//  mem_clk     in   1      single clock; all logic on posedge
//  mem_resetn  in   1      asynchronous, active-low reset
//  cmd_start   in   1      start pulse; sampled only when cmd_busy=0
//  cmd_abort   in   1      request early stop; sticky until honoured
//  cmd_src     in   32     source byte address (bits[1:0] ignored, forced 0)
//  cmd_dst     in   32     destination byte address (bits[1:0] ignored, forced 0)
//  cmd_len     in   LEN_W  number of words to copy
//  cmd_busy    out  1      transfer in progress
//  cmd_done    out  1      one-cycle pulse at end of every accepted command
//  cmd_error   out  1      timeout occurred; held until next accepted cmd_start
//  cmd_count   out  LEN_W  words fully written in current/last command
//  mem_valid   out  1      transaction request
//  mem_wstrb   out  4      0000 read, 1111 write
//  mem_addr    out  32     word-aligned byte address
//  mem_wdata   out  32     write data (last read word)
//  mem_rdata   in   32     read data, valid when mem_valid & mem_ready
//  mem_ready   in   1      completion; may be combinational from mem_valid
// BEHAVIOUR
//  Reset (async, mem_resetn=0): state IDLE; every output 0; pending abort cleared.
//  States: IDLE, RD, RGAP, WR, WGAP, DONE.
//  IDLE: cmd_start=1 -> latch src/dst (low 2 bits 0), len; clear count, error, abort;
//   len!=0 -> RD, busy=1 from next cycle; len==0 -> DONE, no bus activity.
//  cmd_start while busy=1 ignored.
//  RD: valid=1, wstrb=0, addr=src_cur. Transaction completes on an edge with valid&ready:
//   capture rdata into word buffer, src_cur+=4 (mod 2^32), -> RGAP.
//  RGAP: valid=0 for exactly one cycle (lets responder clear its wait pipeline) -> WR.
//  WR: valid=1, wstrb=F, addr=dst_cur, wdata=buffer. On valid&ready: dst_cur+=4 (mod 2^32),
//   count+=1; count==len or abort pending -> DONE, else -> WGAP.
//  WGAP: valid=0 one cycle; abort pending -> DONE, else -> RD.
//  addr/wstrb/wdata stable for the whole time valid=1; valid never drops before ready
//   except on timeout or reset.
//  Abort: honoured only at WR completion or in a GAP state; an aborted RD word is still
//   written (no partial word pairs); cmd_count reports words written.
//  Timeout: counter clears on each valid rise; when valid has been high TIMEOUT_CLOCKS
//   cycles without ready -> valid=0 next cycle, error=1, -> DONE; count not incremented.
//  DONE: cmd_done=1 one cycle, busy=0 in same cycle, -> IDLE; cmd_start in DONE ignored.
//  Latency (ready=valid responder): valid rises the cycle after start is sampled;
//   4 cycles per word; cmd_done high in cycle 4*len after start (cycle 1 if len=0).
//  Address wrap 0xFFFFFFFC+4 -> 0x00000000, no error. Overlapping regions copied
//   ascending, word by word, no overlap correction.
// TESTING
//  1 zero-wait responder, mem[0x10..0x18]=0x11111111/0x22222222/0x33333333, src=0x10,
//    dst=0x43, len=3 -> writes 0x40/0x44/0x48 same data, wstrb=F, done in cycle 12, count=3
//  2 responder WAIT_CLOCKS=3, len=2 -> each valid held 4 cycles, addr/wdata stable,
//    valid low exactly 1 cycle between transactions, done pulse, error=0
//  3 len=0 -> done pulse in cycle 1, mem_valid never high, count=0, busy never high
//  4 mem_ready tied 0, TIMEOUT_CLOCKS=16 -> valid high exactly 16 cycles, then error=1,
//    one done pulse, count=0; next start clears error
//  5 len=4, cmd_abort pulsed during 2nd RD -> 2nd word written, done, count=2; start while
//    busy ignored; new start afterwards copies normally
//  6 src=0xFFFFFFFC len=2 -> 2nd read at 0x00000000; mem_resetn low mid-WR -> all outputs 0
//    immediately, state IDLE, next start runs cleanly

Source files
------------

// File: rtl/nubus_mem_dma.sv
`default_nettype none
// ============================================================================
// Module   : nubus_mem_dma
// Purpose  : Word-copy DMA initiator on the mem_* valid/ready bus
//            (one read then one write per word, with abort and timeout).
// Revision : 1.0 - initial release
// ============================================================================
module nubus_mem_dma #(
    parameter int TIMEOUT_CLOCKS = 255,
    parameter int LEN_W          = 16
) (
    input  logic             mem_clk,
    input  logic             mem_resetn,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic             cmd_error,
    output logic [LEN_W-1:0] cmd_count,
    output logic             mem_valid,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready
);

    localparam int              c_TW     = $clog2(TIMEOUT_CLOCKS + 2);
    localparam int              c_TLIM   = (TIMEOUT_CLOCKS > 0) ? TIMEOUT_CLOCKS - 1 : 0;
    localparam logic [c_TW-1:0] c_TLIM_V = c_TW'(c_TLIM);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RGAP = 3'd2,
        S_WR   = 3'd3,
        S_WGAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic [31:0]       r_buf;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [c_TW-1:0]   r_tcnt;
    logic              r_abort;
    logic              r_error;

    logic              w_abort;
    logic              w_tmo;
    logic [LEN_W-1:0]  w_count_inc;

    // A same-cycle abort request counts as pending so it is not lost at a decision point.
    assign w_abort     = r_abort | cmd_abort;
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_tmo       = (TIMEOUT_CLOCKS != 0) && !mem_ready && (r_tcnt == c_TLIM_V);

    assign cmd_error   = r_error;
    assign cmd_count   = r_count;

    always_comb begin
        w_next    = r_state;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        cmd_busy  = 1'b0;
        cmd_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_next = (cmd_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                mem_valid = 1'b1;
                mem_addr  = r_src;
                cmd_busy  = 1'b1;
                if (w_tmo) begin
                    w_next = S_DONE;
                end else if (mem_ready) begin
                    w_next = S_RGAP;
                end
            end
            S_RGAP: begin
                cmd_busy = 1'b1;
                w_next   = S_WR;
            end
            S_WR: begin
                mem_valid = 1'b1;
                mem_wstrb = 4'hF;
                mem_addr  = r_dst;
                mem_wdata = r_buf;
                cmd_busy  = 1'b1;
                if (w_tmo) begin
                    w_next = S_DONE;
                end else if (mem_ready) begin
                    w_next = ((w_count_inc == r_len) || w_abort) ? S_DONE : S_WGAP;
                end
            end
            S_WGAP: begin
                cmd_busy = 1'b1;
                w_next   = w_abort ? S_DONE : S_RD;
            end
            S_DONE: begin
                cmd_done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            r_state <= S_IDLE;
            r_src   <= 32'h0;
            r_dst   <= 32'h0;
            r_buf   <= 32'h0;
            r_len   <= '0;
            r_count <= '0;
            r_tcnt  <= '0;
            r_abort <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && cmd_start) begin
                r_src   <= {cmd_src[31:2], 2'b00};
                r_dst   <= {cmd_dst[31:2], 2'b00};
                r_len   <= cmd_len;
                r_count <= '0;
                r_error <= 1'b0;
                r_abort <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_abort <= 1'b0;
            end else if (cmd_abort) begin
                r_abort <= 1'b1;
            end

            if (r_state == S_RD && mem_ready) begin
                r_buf <= mem_rdata;
                r_src <= r_src + 32'd4;
            end

            if (r_state == S_WR && mem_ready) begin
                r_dst   <= r_dst + 32'd4;
                r_count <= w_count_inc;
            end

            if ((r_state == S_RD || r_state == S_WR) && w_tmo) begin
                r_error <= 1'b1;
            end

            // Wait counter restarts on every request rise and runs only while valid is held.
            if (w_next != r_state) begin
                r_tcnt <= '0;
            end else if (r_state == S_RD || r_state == S_WR) begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end
        end
    end

endmodule
`default_nettype wire
